// File: rtl/dual_btn_debounce_if.sv
// Raw button inputs and debounced level/edge outputs for the two-channel debouncer.
interface dual_btn_debounce_if;
   logic a_raw;
   logic b_raw;
   logic a_out;
   logic b_out;
   logic a_rise;
   logic a_fall;
   logic b_rise;
   logic b_fall;

   modport master (
      output a_raw, b_raw,
      input  a_out, b_out, a_rise, a_fall, b_rise, b_fall
   );

   modport slave (
      input  a_raw, b_raw,
      output a_out, b_out, a_rise, a_fall, b_rise, b_fall
   );
endinterface

// File: rtl/dual_btn_debounce.sv
// Two independent button channels: 2-flop synchronizer, stability-qualified level FSM,
// and one-cycle rise/fall pulses on accepted level changes.

// state  | meaning
// LOW    | accepted level 0, watching for a 1
// WAIT_H | saw 1, counting consecutive 1 samples before accepting
// HIGH   | accepted level 1, watching for a 0
// WAIT_L | saw 0, counting consecutive 0 samples before accepting
module dual_btn_debounce_chan #(
   parameter int CNT_W           = 20,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic out,
   output logic rise,
   output logic fall
);
   localparam logic [1:0] S_LOW    = 2'd0;
   localparam logic [1:0] S_WAIT_H = 2'd1;
   localparam logic [1:0] S_HIGH   = 2'd2;
   localparam logic [1:0] S_WAIT_L = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         S_LOW: begin
            if (s2) begin
               next_state = S_WAIT_H;
               next_cnt   = '0;
            end
         end
         S_WAIT_H: begin
            if (!s2)                  next_state = S_LOW;
            else if (cnt == CNT_LAST) next_state = S_HIGH;
            else                      next_cnt   = cnt + CNT_W'(1);
         end
         S_HIGH: begin
            if (!s2) begin
               next_state = S_WAIT_L;
               next_cnt   = '0;
            end
         end
         default: begin
            if (s2)                   next_state = S_HIGH;
            else if (cnt == CNT_LAST) next_state = S_LOW;
            else                      next_cnt   = cnt + CNT_W'(1);
         end
      endcase
   end

   // Outputs are registered from next_state so they move on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= S_LOW;
         cnt   <= '0;
         out   <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         state <= next_state;
         cnt   <= next_cnt;
         out   <= (next_state == S_HIGH) || (next_state == S_WAIT_L);
         rise  <= (state == S_WAIT_H) && (next_state == S_HIGH);
         fall  <= (state == S_WAIT_L) && (next_state == S_LOW);
      end
   end
endmodule

module dual_btn_debounce #(
   parameter int CNT_W           = 20,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic              clk,
   input logic              rst,
   dual_btn_debounce_if.slave bus
);
   dual_btn_debounce_chan #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.a_raw),
      .out  (bus.a_out),
      .rise (bus.a_rise),
      .fall (bus.a_fall)
   );

   dual_btn_debounce_chan #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.b_raw),
      .out  (bus.b_out),
      .rise (bus.b_rise),
      .fall (bus.b_fall)
   );
endmodule
